// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: instruction fetch front end.
// Drives a synchronous-read instruction memory, tracks the one-cycle read
// latency with req_q, and buffers {instruction, pc+1} pairs in a small
// queue that decode drains over a valid/ready handshake.
module fetch_queue_stage #(
    parameter int                   PC_W    = 7,
    parameter int                   INSTR_W = 32,
    parameter int                   DEPTH   = 4,
    parameter logic [INSTR_W-1:0]   NOP     = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enbl,
    input  logic                        redirect,
    input  logic [PC_W-1:0]             redirect_pc,
    output logic [PC_W-1:0]             imem_addr,
    input  logic [INSTR_W-1:0]          imem_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTR_W-1:0]          out_instr,
    output logic [PC_W-1:0]             out_pc_next,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Fetch state
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               req_q, req_d;
    logic [PC_W-1:0]    req_pc_next_q, req_pc_next_d;   // pc+1 tag of the in-flight word

    // Queue state
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pcn_mem   [DEPTH];

    // Handshake / control
    logic               issue;
    logic               push;
    logic               pop;
    logic [CW:0]        credit_used;
    logic [PC_W-1:0]    pc_plus1;

    assign pc_plus1    = pc_q + PC_W'(1);
    // In-flight request counts against capacity; a same-cycle pop does not
    // free a slot, which keeps the check independent of out_ready.
    assign credit_used = {1'b0, count_q} + (CW+1)'(req_q);
    assign issue       = enbl & ~redirect & (credit_used < (CW+1)'(DEPTH));
    assign push        = req_q & ~redirect;
    assign pop         = out_valid & out_ready & ~redirect;

    assign imem_addr   = pc_q;
    assign out_valid   = (count_q != '0);
    assign out_instr   = out_valid ? instr_mem[rd_ptr_q] : NOP;
    assign out_pc_next = out_valid ? pcn_mem[rd_ptr_q] : '0;
    assign count       = count_q;

    // Next-state for PC, request tracking and queue pointers/occupancy
    always_comb begin
        pc_d          = pc_q;
        req_d         = 1'b0;
        req_pc_next_d = req_pc_next_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (redirect) begin
            // Flush: drop queue contents and the word returning next cycle
            pc_d     = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d          = pc_plus1;
                req_d         = 1'b1;
                req_pc_next_d = pc_plus1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers, cleared immediately by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= '0;
            req_q         <= 1'b0;
            req_pc_next_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            req_q         <= req_d;
            req_pc_next_q <= req_pc_next_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage: data is don't-care while count is zero, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pcn_mem[wr_ptr_q]   <= req_pc_next_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage (PC_W=7, DEPTH=4, NOP=0).
// Memory model: word at address k is 0x1000+k, synchronous read.
module tb_fetch_queue_stage;

    localparam int PC_W    = 7;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               enbl;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc_next;
    logic [2:0]         count;

    int n_pass  = 0;
    int n_total = 0;

    fetch_queue_stage #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .NOP('0)
    ) dut (
        .clk(clk), .rst(rst), .enbl(enbl), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc_next(out_pc_next), .count(count)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory
    always @(posedge clk) imem_rdata <= 32'h1000 + 32'(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic head(input string tag, input logic v, input logic [31:0] instr,
                        input logic [31:0] pcn);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_instr"}, out_instr, instr);
        chk({tag, "_pcn"}, 32'(out_pc_next), pcn);
        $display("%0t %s valid=%0d instr=%h pcn=%h count=%0d addr=%h",
                 $time, tag, out_valid, out_instr, out_pc_next, count, imem_addr);
    endtask

    // Occupancy must never exceed DEPTH
    always @(negedge clk) if (!rst) chk("no_overflow", 32'(count <= 3'(DEPTH)), 32'd1);

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enbl = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Reset values
        head("reset", 1'b0, 32'h0, 32'h0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_addr", 32'(imem_addr), 32'd0);

        // Streaming: 2-edge latency, then one word per cycle
        rst = 1'b0; enbl = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        head("stream_e1", 1'b0, 32'h0, 32'h0);
        chk("stream_e1_addr", 32'(imem_addr), 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            head("stream", 1'b1, 32'h1000 + 32'(k), 32'(k + 1));
        end

        // Back-pressure: fill to DEPTH, issue stops at PC=4
        do_reset();
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("bp_count", 32'(count), 32'd4);
        chk("bp_addr", 32'(imem_addr), 32'd4);
        head("bp_hold", 1'b1, 32'h1000, 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            head("bp_drain", 1'b1, 32'h1000 + 32'(k), 32'(k + 1));
            @(negedge clk);
        end

        // Redirect with 2 entries queued and one request in flight
        do_reset();
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rd_pre_count", 32'(count), 32'd2);
        redirect = 1'b1; redirect_pc = 7'h50;
        @(negedge clk);
        redirect = 1'b0; out_ready = 1'b1;
        head("rd_flush", 1'b0, 32'h0, 32'h0);
        chk("rd_flush_count", 32'(count), 32'd0);
        chk("rd_flush_addr", 32'(imem_addr), 32'h50);
        @(negedge clk);
        head("rd_e2", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        head("rd_first", 1'b1, 32'h1050, 32'h51);
        @(negedge clk);
        head("rd_second", 1'b1, 32'h1051, 32'h52);

        // PC wrap: redirect to 0x7E
        redirect = 1'b1; redirect_pc = 7'h7E;
        @(negedge clk);
        redirect = 1'b0;
        head("wrap_flush", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wrap_addr_7f", 32'(imem_addr), 32'h7F);
        @(negedge clk);
        head("wrap_h0", 1'b1, 32'h107E, 32'h7F);
        chk("wrap_addr_0", 32'(imem_addr), 32'h0);
        @(negedge clk);
        head("wrap_h1", 1'b1, 32'h107F, 32'h00);
        @(negedge clk);
        head("wrap_h2", 1'b1, 32'h1000, 32'h01);

        // Freeze with one request in flight (word 0x1001 pending, PC=2)
        enbl = 1'b0;
        @(negedge clk);
        head("frz_inflight", 1'b1, 32'h1001, 32'h2);
        chk("frz_addr1", 32'(imem_addr), 32'd2);
        @(negedge clk);
        head("frz_empty", 1'b0, 32'h0, 32'h0);
        chk("frz_addr2", 32'(imem_addr), 32'd2);
        @(negedge clk);
        chk("frz_addr3", 32'(imem_addr), 32'd2);
        enbl = 1'b1;
        @(negedge clk);
        head("frz_resume_e1", 1'b0, 32'h0, 32'h0);
        chk("frz_resume_addr", 32'(imem_addr), 32'd3);
        @(negedge clk);
        head("frz_resume", 1'b1, 32'h1002, 32'h3);

        // Asynchronous reset between edges with a full queue
        out_ready = 1'b0;
        repeat (8) @(negedge clk);
        chk("ar_full", 32'(count), 32'd4);
        #2 rst = 1'b1;
        #1;
        head("ar_async", 1'b0, 32'h0, 32'h0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
